// File: rtl/rv32m_pkg.sv
// Shared types, constants and opcode helpers for the RV32M multiply/divide unit.
package rv32m_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Architectural results for the divide special cases
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // rs1 is treated as two's complement
    function automatic logic a_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement
    function automatic logic b_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv32m_muldiv_if.sv
// Request / writeback bundle between the issue controller and the muldiv unit.
interface rv32m_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      dst_num;
    logic            busy;
    logic            done;
    logic            wb_we;
    logic [4:0]      wb_dst_num;
    logic [XLEN-1:0] result;

    // Issue controller side
    modport master (
        output start, funct3, op_a, op_b, dst_num,
        input  busy, done, wb_we, wb_dst_num, result
    );

    // Execution unit side
    modport slave (
        input  start, funct3, op_a, op_b, dst_num,
        output busy, done, wb_we, wb_dst_num, result
    );
endinterface

// File: rtl/rv32m_div_core.sv
// Unsigned restoring divider: a 2*XLEN remainder:quotient register advanced by
// one shift-subtract step per enabled clock. After XLEN steps the upper half
// holds the remainder and the lower half the quotient. The *_nxt outputs show
// the value the register takes after the current step.
module rv32m_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot_nxt,
    output logic [XLEN-1:0] rem_nxt
);
    logic [2*XLEN-1:0] rq_q, rq_d;
    logic [2*XLEN-1:0] rq_step;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial = rq_q[2*XLEN-1:XLEN-1];
        diff  = trial - {1'b0, divisor};
        if (trial >= {1'b0, divisor}) begin
            rq_step = {diff[XLEN-1:0], rq_q[XLEN-2:0], 1'b1};
        end else begin
            rq_step = {trial[XLEN-1:0], rq_q[XLEN-2:0], 1'b0};
        end
        quot_nxt = rq_step[XLEN-1:0];
        rem_nxt  = rq_step[2*XLEN-1:XLEN];
    end

    // Load a new dividend or advance one step
    always_comb begin
        rq_d = rq_q;
        if (load) begin
            rq_d = {{XLEN{1'b0}}, dividend};
        end else if (en) begin
            rq_d = rq_step;
        end
    end

    // Remainder:quotient register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rq_q <= '0;
        end else begin
            rq_q <= rq_d;
        end
    end
endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit. FSM IDLE -> CALC (XLEN radix-2 steps)
// -> DONE (one-cycle result pulse). Divide-by-zero and signed overflow finish
// straight from IDLE. Operands are converted to magnitudes on accept and the
// sign is restored on the way into DONE.
// Build option: define RV32M_FAST_MUL_EN to compute all multiplies with a
// single-cycle 33x33 signed multiplier; divides stay iterative.
module rv32m_muldiv
    import rv32m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    rv32m_muldiv_if.slave      bus
);
    state_e            state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic [4:0]        dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   result_q, result_d;

    muldiv_op_e        op_in;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step, prod_fix;
    logic [XLEN-1:0]   div_mag, div_fix;
    logic              div_load, div_en;
    logic [XLEN-1:0]   quot_nxt, rem_nxt;

`ifdef RV32M_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;

    assign fast_a = {a_signed(op_in) & bus.op_a[XLEN-1], bus.op_a};
    assign fast_b = {b_signed(op_in) & bus.op_b[XLEN-1], bus.op_b};
    assign fast_p = fast_a * fast_b;
`endif

    rv32m_div_core #(.XLEN(XLEN)) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .en       (div_en),
        .dividend (a_mag),
        .divisor  (b_q),
        .quot_nxt (quot_nxt),
        .rem_nxt  (rem_nxt)
    );

    // Decode the incoming request into operand signs and magnitudes
    always_comb begin
        op_in = muldiv_op_e'(bus.funct3);
        a_neg = a_signed(op_in) && bus.op_a[XLEN-1];
        b_neg = b_signed(op_in) && bus.op_b[XLEN-1];
        a_mag = a_neg ? -bus.op_a : bus.op_a;
        b_mag = b_neg ? -bus.op_b : bus.op_b;
    end

    // Shift-add multiply step and sign fix-up of the final values
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {mul_sum, prod_q[XLEN-1:1]};
        prod_fix  = neg_q ? -prod_step : prod_step;
        div_mag   = is_rem(op_q) ? rem_nxt : quot_nxt;
        div_fix   = neg_q ? -div_mag : div_mag;
    end

    // Controller next state: accept, iterate, finish
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        div_load = 1'b0;
        div_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = op_in;
                    dst_d    = bus.dst_num;
                    a_d      = a_mag;
                    b_d      = b_mag;
                    neg_d    = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
                    cnt_d    = '0;
                    prod_d   = {{XLEN{1'b0}}, b_mag};
                    div_load = 1'b1;
                    state_d  = CALC;
                    if (is_div(op_in) && bus.op_b == '0) begin
                        result_d = is_rem(op_in) ? bus.op_a : DIV0_QUOT;
                        state_d  = DONE;
                    end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                                 bus.op_a == INT_MIN && bus.op_b == '1) begin
                        result_d = (op_in == OP_REM) ? '0 : INT_MIN;
                        state_d  = DONE;
                    end
`ifdef RV32M_FAST_MUL_EN
                    else if (!is_div(op_in)) begin
                        result_d = (op_in == OP_MUL) ? fast_p[XLEN-1:0]
                                                     : fast_p[2*XLEN-1:XLEN];
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div(op_q)) begin
                    div_en = 1'b1;
                end else begin
                    prod_d = prod_step;
                end
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = DONE;
                    if (is_div(op_q)) begin
                        result_d = div_fix;
                    end else if (op_q == OP_MUL) begin
                        result_d = prod_fix[XLEN-1:0];
                    end else begin
                        result_d = prod_fix[2*XLEN-1:XLEN];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset along with the control
            // state so the whole unit comes out of reset in a known state.
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            dst_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop updates from
            // values sampled before the edge regardless of statement order.
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    // Outputs decode directly from registered state
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.wb_we      = bus.done && (dst_q != '0);
    assign bus.wb_dst_num = dst_q;
    assign bus.result     = result_q;
endmodule

// File: doc/rv32m_muldiv.md
Name: rv32m_muldiv

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file read ports: operands come from srcreg1_value/srcreg2_value.
- It is also directly upstream of the register file write port: done/wb_we/wb_dst_num/result drive we/dstreg_num/dstreg_value.
- Multi-cycle: the controller stalls on busy.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when busy=0
funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a  input  32  rs1 value
op_b  input  32  rs2 value
dst_num  input  5  rd number
busy  output  1  unit occupied (state != IDLE)
done  output  1  one-cycle result-valid pulse
wb_we  output  1  done && wb_dst_num != 0
wb_dst_num  output  5  rd captured at start
result  output  32  result, held stable from done until next accepted start

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous, active-low, rst_n.
- Reset (rst_n=0 at an edge), including mid-operation:
  - state=IDLE, busy=0, done=0, wb_we=0, wb_dst_num=0, result=0, counter=0.
  - Any in-flight operation is discarded; no done pulse.
- States:
  - IDLE: start=1 at edge E0 latches funct3, op_a, op_b, dst_num.
    - Special case detected: go to DONE.
    - Otherwise: take operand magnitudes per signedness, counter=0, go to CALC.
  - CALC: one radix-2 iteration per edge.
    - Multiply: shift-add into a 64-bit product.
    - Divide: restoring shift-subtract on a 64-bit remainder:quotient register.
    - Counter increments each edge. The iteration with counter==31 transitions to DONE, at edge E32.
  - DONE: done=1 for exactly one cycle, result applies sign fix-up. Next edge returns to IDLE.
  - start is ignored while busy=1, including the DONE cycle; there is no queueing.
- Latency:
  - Normal ops: done high in the cycle after E32 (32 cycles after the accepting edge).
  - Special cases: done high in the cycle after E0.
- Signedness:
  - MULH: both signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - DIV/REM: signed.
  - Product negated if exactly one signed operand is negative.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
- Result select: MUL returns product[31:0]; MULH* return product[63:32].
- Special cases (RISC-V spec values):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- dst_num=0: the operation still runs, done pulses, wb_we=0.
- start coincident with rst_n=0: reset wins.

Optional Feature:
- Macro: RV32M_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a combinational 33x33 signed multiplier. IDLE goes straight to DONE, so done is high the cycle after E0. Divide ops are unchanged.
- Undefined: all ops are iterative, as above.

Decomposition:
- Package rv32m_pkg:
  - muldiv_op_e enum (8 funct3 encodings).
  - state_e enum (IDLE, CALC, DONE).
  - Constants DIV0_QUOT=32'hFFFF_FFFF and INT_MIN=32'h8000_0000.
  - Helper functions is_div(op), a_signed(op), b_signed(op).
- Sub-module rv32m_div_core: unsigned iterative restoring divider step logic (64-bit rem:quot register, one step per enable). The top keeps the FSM, the multiplier path, sign handling and special cases.

Test Plan:
- MUL 7 × 6, dst 5, start at E0 → busy=1, done and wb_we high only in cycle after E32, result=42, wb_dst_num=5 (with RV32M_FAST_MUL_EN: cycle after E0).
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0; MULHU same → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each done the cycle after E0; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- start pulsed during CALC and during DONE → ignored, no second done. rst_n=0 at counter=10 → busy=0, result=0, no done. New start after reset completes normally.
- dst_num=0 with DIVU 9/3 → done=1, wb_we=0, result=3.
